// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
//  Shared definitions for the RAM-backed FIFO controller: FIFO capacity,
//  the controller state encoding and the RAM rw pin encoding.
package ram_fifo_pkg;

    // FIFO capacity: the whole 1Kx8 RAM is used as ring storage.
    localparam int DEPTH = 1024;

    // Operation driven on the RAM port during the current cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
//  FIFO-side bundle of the controller.
//  Producer : push_valid, push_data -> push_ready
//  Consumer : pop_req -> pop_ready, pop_data, pop_valid
//  Status   : full, empty, count (occupancy 0..2**ADDR_W)
//  master = the client that pushes and pops; slave = the controller.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_req;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_ready, pop_data, pop_valid, full, empty, count
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_ready, pop_data, pop_valid, full, empty, count
    );
endinterface

// File: rtl/ram_fifo_rd_pipe.sv
// ram_fifo_rd_pipe
//  Valid-tag delay line RD_LAT+1 stages deep. A tag entered at the edge that
//  issues a RAM read emerges on tag_out while ram_out holds that read's data,
//  so the top can capture it at the following edge.
//  Ports: clk, rst (async, active high), tag_in, tag_out.
module ram_fifo_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out
);

    logic [RD_LAT:0] pipe_r;

    // Shift register of read tags; reset flushes any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_r <= {(RD_LAT + 1){1'b0}};
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag_out = pipe_r[RD_LAT];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//  Turns a single-port synchronous RAM into a circular FIFO. At most one RAM
//  operation issues per cycle; when push and pop both want the port, the
//  grant alternates (the op that did not run last cycle wins).
//  Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fifo            ram_fifo_ctrl_if.slave: push/pop handshakes and status
//   ram_in/addr/rw  registered RAM port (rw: 1=write, 0=read)
//   ram_out         RAM read data, valid RD_LAT cycles after a read address
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    ram_fifo_ctrl_if.slave    fifo,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     count_r;
    logic                full_r;
    logic                empty_r;
    logic [DATA_W-1:0]   ram_in_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic                ram_rw_r;
    logic                pop_valid_r;
    logic [DATA_W-1:0]   pop_data_r;

    logic                want_w_s;
    logic                want_r_s;
    logic                pop_pri_s;
    logic                push_ready_s;
    logic                pop_ready_s;
    logic                push_acc_s;
    logic                pop_acc_s;
    logic [ADDR_W:0]     count_next_s;
    logic                tag_out_s;

    // Arbiter: pop has priority unless the port was reading this cycle.
    // push_acc_s and pop_acc_s are mutually exclusive by construction.
    always_comb begin
        want_w_s = fifo.push_valid & ~full_r;
        want_r_s = fifo.pop_req & ~empty_r;
        if (state_r == S_RD) begin
            pop_pri_s = 1'b0;
        end else begin
            pop_pri_s = 1'b1;
        end
        push_ready_s = ~full_r & ~(want_r_s & pop_pri_s);
        pop_ready_s  = ~empty_r & ~(want_w_s & ~pop_pri_s);
        push_acc_s   = fifo.push_valid & push_ready_s;
        pop_acc_s    = fifo.pop_req & pop_ready_s;
    end

    // Next occupancy; full/empty are registered from it, never from pointers.
    always_comb begin
        count_next_s = count_r;
        if (push_acc_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_acc_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // FSM with RAM-port registers, pointers and occupancy. A write is placed
    // on the port at edge k and lands in the RAM at k+1; a pop of that word
    // can at the earliest issue its read at k+1, so no bypass is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            ram_in_r   <= {DATA_W{1'b0}};
            ram_addr_r <= {ADDR_W{1'b0}};
            ram_rw_r   <= RW_READ;
        end else begin
            if (push_acc_s) begin
                state_r    <= S_WR;
                ram_rw_r   <= RW_WRITE;
                ram_addr_r <= wr_ptr_r;
                ram_in_r   <= fifo.push_data;
                wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            end else if (pop_acc_s) begin
                state_r    <= S_RD;
                ram_rw_r   <= RW_READ;
                ram_addr_r <= rd_ptr_r;
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
            end else begin
                // Idle: park the port in read mode so nothing is overwritten.
                state_r    <= S_IDLE;
                ram_rw_r   <= RW_READ;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    ram_fifo_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (pop_acc_s),
        .tag_out (tag_out_s)
    );

    // Read return: when the tag emerges ram_out holds the popped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_valid_r <= 1'b0;
            pop_data_r  <= {DATA_W{1'b0}};
        end else begin
            pop_valid_r <= tag_out_s;
            if (tag_out_s) begin
                pop_data_r <= ram_out;
            end else begin
                pop_data_r <= pop_data_r;
            end
        end
    end

    assign fifo.push_ready = push_ready_s;
    assign fifo.pop_ready  = pop_ready_s;
    assign fifo.pop_data   = pop_data_r;
    assign fifo.pop_valid  = pop_valid_r;
    assign fifo.full       = full_r;
    assign fifo.empty      = empty_r;
    assign fifo.count      = count_r;
    assign ram_in          = ram_in_r;
    assign ram_addr        = ram_addr_r;
    assign ram_rw          = ram_rw_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
//  Directed bench for ram_fifo_ctrl with a behavioural 1Kx8 single-port RAM
//  (RD_LAT=1: write on rw=1, otherwise registered read).
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] ram_in;
    logic [9:0] ram_addr;
    logic       ram_rw;
    logic [7:0] ram_out;
    logic [7:0] mem [0:1023];
    logic [7:0] popq [$];
    int         checks;
    int         errors;

    ram_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(10)) fif ();

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(10), .RD_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo     (fif),
        .ram_in   (ram_in),
        .ram_addr (ram_addr),
        .ram_rw   (ram_rw),
        .ram_out  (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_in;
        else        ram_out <= mem[ram_addr];
    end

    // Records every popped word
    always @(negedge clk) begin
        if (fif.pop_valid === 1'b1) popq.push_back(fif.pop_data);
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fif.push_valid = 1'b0;
        fif.push_data  = 8'h00;
        fif.pop_req    = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fif.count !== 11'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fif.count); end
        checks++; if (fif.empty !== 1'b1 || fif.full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b expected 1 0", fif.empty, fif.full); end
        checks++; if (ram_rw !== 1'b0 || ram_addr !== 10'd0 || ram_in !== 8'h00) begin errors++; $display("FAIL reset_ramport: rw=%b addr=%h in=%h expected 0 000 00", ram_rw, ram_addr, ram_in); end
        checks++; if (fif.pop_valid !== 1'b0 || fif.pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop: valid=%b data=%h expected 0 00", fif.pop_valid, fif.pop_data); end
        checks++; if (fif.push_ready !== 1'b1 || fif.pop_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: push_ready=%b pop_ready=%b expected 1 0", fif.push_ready, fif.pop_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] v [3];
        v = '{8'h03, 8'h01, 8'h00};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fif.push_valid = 1'b1;
            fif.push_data  = v[i];
            #1;
            checks++; if (fif.push_ready !== 1'b1) begin errors++; $display("FAIL basic_push_ready: got %b expected 1", fif.push_ready); end
            cycle();
            checks++; if (ram_rw !== 1'b1 || ram_addr !== 10'(i) || ram_in !== v[i]) begin errors++; $display("FAIL basic_write: rw=%b addr=%h in=%h expected 1 %h %h", ram_rw, ram_addr, ram_in, 10'(i), v[i]); end
        end
        fif.push_valid = 1'b0;
        checks++; if (fif.count !== 11'd3) begin errors++; $display("FAIL basic_count3: got %0d expected 3", fif.count); end
        for (int i = 0; i < 3; i++) begin
            fif.pop_req = 1'b1;
            #1;
            checks++; if (fif.pop_ready !== 1'b1) begin errors++; $display("FAIL basic_pop_ready: got %b expected 1", fif.pop_ready); end
            cycle();
            fif.pop_req = 1'b0;
            checks++; if (ram_rw !== 1'b0 || ram_addr !== 10'(i) || fif.pop_valid !== 1'b0) begin errors++; $display("FAIL basic_read_issue: rw=%b addr=%h valid=%b expected 0 %h 0", ram_rw, ram_addr, fif.pop_valid, 10'(i)); end
            cycle();
            checks++; if (fif.pop_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", fif.pop_valid); end
            cycle();
            checks++; if (fif.pop_valid !== 1'b1 || fif.pop_data !== v[i]) begin errors++; $display("FAIL basic_pop_data: valid=%b data=%h expected 1 %h", fif.pop_valid, fif.pop_data, v[i]); end
        end
        cycle();
        checks++; if (fif.pop_valid !== 1'b0) begin errors++; $display("FAIL basic_strobe_len: got %b expected 0", fif.pop_valid); end
        checks++; if (fif.empty !== 1'b1 || fif.count !== 11'd0) begin errors++; $display("FAIL basic_empty: empty=%b count=%0d expected 1 0", fif.empty, fif.count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            fif.push_valid = 1'b1;
            fif.push_data  = 8'(i);
            cycle();
        end
        fif.push_data = 8'hA5;
        #1;
        checks++; if (fif.full !== 1'b1 || fif.count !== 11'd1024) begin errors++; $display("FAIL full_flag: full=%b count=%0d expected 1 1024", fif.full, fif.count); end
        checks++; if (fif.push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready: got %b expected 0", fif.push_ready); end
        cycle();
        cycle();
        checks++; if (ram_rw !== 1'b0 || fif.count !== 11'd1024) begin errors++; $display("FAIL full_no_write: rw=%b count=%0d expected 0 1024", ram_rw, fif.count); end
        fif.pop_req = 1'b1;
        #1;
        checks++; if (fif.pop_ready !== 1'b1 || fif.push_ready !== 1'b0) begin errors++; $display("FAIL full_both: pop_ready=%b push_ready=%b expected 1 0", fif.pop_ready, fif.push_ready); end
        cycle();
        fif.pop_req = 1'b0;
        #1;
        checks++; if (fif.count !== 11'd1023 || fif.full !== 1'b0 || ram_addr !== 10'd0) begin errors++; $display("FAIL full_pop: count=%0d full=%b addr=%h expected 1023 0 000", fif.count, fif.full, ram_addr); end
        checks++; if (fif.push_ready !== 1'b1) begin errors++; $display("FAIL full_push_resume: got %b expected 1", fif.push_ready); end
        cycle();
        fif.push_valid = 1'b0;
        checks++; if (ram_rw !== 1'b1 || ram_addr !== 10'd0 || ram_in !== 8'hA5) begin errors++; $display("FAIL full_1025th: rw=%b addr=%h in=%h expected 1 000 a5", ram_rw, ram_addr, ram_in); end
        checks++; if (fif.full !== 1'b1 || fif.count !== 11'd1024) begin errors++; $display("FAIL full_refill: full=%b count=%0d expected 1 1024", fif.full, fif.count); end
        cycle();
        checks++; if (fif.pop_valid !== 1'b1 || fif.pop_data !== 8'h00) begin errors++; $display("FAIL full_pop_data: valid=%b data=%h expected 1 00", fif.pop_valid, fif.pop_data); end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_q [9];
        logic [10:0] exp_cnt;
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h23, 8'h25, 8'h27};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fif.push_valid = 1'b1;
            fif.push_data  = 8'h10 + 8'(i);
            cycle();
        end
        popq.delete();
        for (int j = 0; j < 8; j++) begin
            fif.push_valid = 1'b1;
            fif.pop_req    = 1'b1;
            fif.push_data  = 8'h20 + 8'(j);
            #1;
            if (j % 2 == 0) begin
                checks++; if (fif.pop_ready !== 1'b1 || fif.push_ready !== 1'b0) begin errors++; $display("FAIL alt_grant_r j=%0d: pop_ready=%b push_ready=%b expected 1 0", j, fif.pop_ready, fif.push_ready); end
                exp_cnt = 11'd4;
            end else begin
                checks++; if (fif.push_ready !== 1'b1 || fif.pop_ready !== 1'b0) begin errors++; $display("FAIL alt_grant_w j=%0d: push_ready=%b pop_ready=%b expected 1 0", j, fif.push_ready, fif.pop_ready); end
                exp_cnt = 11'd5;
            end
            cycle();
            checks++; if (fif.count !== exp_cnt) begin errors++; $display("FAIL alt_count j=%0d: got %0d expected %0d", j, fif.count, exp_cnt); end
        end
        fif.push_valid = 1'b0;
        fif.pop_req    = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        fif.pop_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (popq.size() != 9) begin errors++; $display("FAIL alt_pop_count: got %0d expected 9", popq.size()); end
        for (int i = 0; i < 9; i++) begin
            if (i < popq.size()) begin
                checks++; if (popq[i] !== exp_q[i]) begin errors++; $display("FAIL alt_order i=%0d: got %h expected %h", i, popq[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_empty_both();
        do_reset();
        fif.push_valid = 1'b1;
        fif.pop_req    = 1'b1;
        fif.push_data  = 8'h5A;
        #1;
        checks++; if (fif.push_ready !== 1'b1 || fif.pop_ready !== 1'b0) begin errors++; $display("FAIL empty_both: push_ready=%b pop_ready=%b expected 1 0", fif.push_ready, fif.pop_ready); end
        cycle();
        #1;
        checks++; if (fif.pop_ready !== 1'b1 || fif.push_ready !== 1'b0) begin errors++; $display("FAIL empty_next_grant: pop_ready=%b push_ready=%b expected 1 0", fif.pop_ready, fif.push_ready); end
        cycle();
        fif.push_valid = 1'b0;
        fif.pop_req    = 1'b0;
        checks++; if (fif.count !== 11'd0 || ram_rw !== 1'b0) begin errors++; $display("FAIL empty_after_pop: count=%0d rw=%b expected 0 0", fif.count, ram_rw); end
        cycle();
        cycle();
        checks++; if (fif.pop_valid !== 1'b1 || fif.pop_data !== 8'h5A) begin errors++; $display("FAIL empty_return: valid=%b data=%h expected 1 5a", fif.pop_valid, fif.pop_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fif.push_valid = 1'b1;
        fif.push_data  = 8'h77;
        cycle();
        fif.push_valid = 1'b0;
        fif.pop_req    = 1'b1;
        cycle();
        fif.pop_req = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        checks++; if (fif.pop_valid !== 1'b0 || ram_rw !== 1'b0) begin errors++; $display("FAIL rstmid_async: valid=%b rw=%b expected 0 0", fif.pop_valid, ram_rw); end
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (fif.pop_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid i=%0d: got %b expected 0", i, fif.pop_valid); end
        end
        checks++; if (fif.count !== 11'd0 || ram_rw !== 1'b0) begin errors++; $display("FAIL rstmid_state: count=%0d rw=%b expected 0 0", fif.count, ram_rw); end
        fif.push_valid = 1'b1;
        fif.push_data  = 8'h3C;
        cycle();
        fif.push_valid = 1'b0;
        checks++; if (ram_rw !== 1'b1 || ram_addr !== 10'd0 || ram_in !== 8'h3C) begin errors++; $display("FAIL rstmid_push_addr0: rw=%b addr=%h in=%h expected 1 000 3c", ram_rw, ram_addr, ram_in); end
        rst = 1'b1;
        #1;
        checks++; if (ram_rw !== 1'b0 || ram_addr !== 10'd0) begin errors++; $display("FAIL rstmid_rw_drop: rw=%b addr=%h expected 0 000", ram_rw, ram_addr); end
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_wrap();
        logic [7:0] sbq [$];
        logic [7:0] expq [$];
        logic [7:0] d;
        logic [7:0] exp_d;
        int         m_count;
        int         m_last;
        logic       pv, pr, ww, wr, pri, e_pr, e_rr, e_push, e_pop;
        do_reset();
        m_count = 0;
        m_last  = 0;
        for (int it = 0; it < 3500; it++) begin
            if (it < 1000) begin
                pv = 1'b1; pr = 1'b0;
            end else if (it < 2000) begin
                pv = 1'b0; pr = 1'b1;
            end else begin
                pv = ($urandom_range(0, 99) < 55);
                pr = ($urandom_range(0, 99) < 50);
            end
            d = 8'($urandom);
            fif.push_valid = pv;
            fif.push_data  = d;
            fif.pop_req    = pr;
            #1;
            ww   = pv && (m_count != 1024);
            wr   = pr && (m_count != 0);
            pri  = (m_last != 2);
            e_pr = (m_count != 1024) && !(wr && pri);
            e_rr = (m_count != 0) && !(ww && !pri);
            e_push = pv && e_pr;
            e_pop  = pr && e_rr;
            checks++; if (fif.push_ready !== e_pr || fif.pop_ready !== e_rr) begin errors++; $display("FAIL wrap_ready it=%0d: push_ready=%b pop_ready=%b expected %b %b", it, fif.push_ready, fif.pop_ready, e_pr, e_rr); end
            if (e_push) begin
                sbq.push_back(d); m_count++; m_last = 1;
            end else if (e_pop) begin
                expq.push_back(sbq.pop_front()); m_count--; m_last = 2;
            end else begin
                m_last = 0;
            end
            cycle();
            checks++; if (ram_rw !== e_push) begin errors++; $display("FAIL wrap_rw it=%0d: got %b expected %b", it, ram_rw, e_push); end
            checks++; if (fif.count !== 11'(m_count)) begin errors++; $display("FAIL wrap_count it=%0d: got %0d expected %0d", it, fif.count, m_count); end
            if (fif.pop_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL wrap_extra_pop it=%0d: got data %h expected no pop_valid", it, fif.pop_data);
                end else begin
                    exp_d = expq.pop_front();
                    if (fif.pop_data !== exp_d) begin errors++; $display("FAIL wrap_data it=%0d: got %h expected %h", it, fif.pop_data, exp_d); end
                end
            end
        end
        fif.push_valid = 1'b0;
        fif.pop_req    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (fif.pop_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL wrap_extra_pop drain: got data %h expected no pop_valid", fif.pop_data);
                end else begin
                    exp_d = expq.pop_front();
                    if (fif.pop_data !== exp_d) begin errors++; $display("FAIL wrap_data drain: got %h expected %h", fif.pop_data, exp_d); end
                end
            end
        end
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL wrap_missing: %0d pops outstanding, expected 0", expq.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        fif.push_valid = 1'b0;
        fif.push_data  = 8'h00;
        fif.pop_req    = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_alternate();
        test_empty_both();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
